// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_pkg : ALU opcodes, opcode legality check and sequencer FSM states
// Rev 1.0
// ----------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_SLT, ALU_SLL, ALU_SRL: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_rr_pick : two-way round-robin picker, one-hot grant
// Rev 1.0
// ----------------------------------------------------------------------
module alu_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_arbiter : shares one combinational ALU between two requesters
// Rev 1.0
// ----------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_op,
  input  logic [2*DATA_W-1:0]  req_a,
  input  logic [2*DATA_W-1:0]  req_b,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  output logic [DATA_W-1:0]    alu_in1,
  output logic [DATA_W-1:0]    alu_in2,
  output logic [3:0]           alu_op,
  output logic [SHAMT_W-1:0]   alu_shamt,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_equal,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [DATA_W-1:0]    rsp_result,
  output logic                 rsp_equal,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     ops_done
);

  state_e               state_q;
  logic                 last_grant_q;
  logic                 id_q;
  logic                 illegal_q;
  logic [DATA_W-1:0]    alu_in1_q;
  logic [DATA_W-1:0]    alu_in2_q;
  logic [3:0]           alu_op_q;
  logic [SHAMT_W-1:0]   alu_shamt_q;
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [DATA_W-1:0]    rsp_result_q;
  logic                 rsp_equal_q;
  logic                 rsp_err_q;
  logic [CNT_W-1:0]     ops_done_q;
  logic [CNT_W-1:0]     ops_done_d;

  logic [1:0]           w_grant;
  logic                 w_accept;
  logic                 w_sel;
  logic                 w_legal;
  logic [3:0]           w_op;
  logic [DATA_W-1:0]    w_a;
  logic [DATA_W-1:0]    w_b;
  logic [SHAMT_W-1:0]   w_shamt;

  alu_rr_pick u_pick (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  assign req_ready  = (state_q == ST_IDLE) ? w_grant : 2'b00;
  assign w_accept   = |(req_valid & req_ready);
  assign w_sel      = w_grant[1];
  assign w_op       = w_sel ? req_op[7:4] : req_op[3:0];
  assign w_a        = w_sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign w_b        = w_sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign w_shamt    = w_sel ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
  assign w_legal    = op_legal(w_op);
  assign ops_done_d = ops_done_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      illegal_q    <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= ALU_AND;
      alu_shamt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_equal_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            // Illegal codes park the ALU on a harmless all-zero AND.
            alu_op_q     <= w_legal ? w_op : ALU_AND;
            alu_in1_q    <= w_legal ? w_a : '0;
            alu_in2_q    <= w_legal ? w_b : '0;
            alu_shamt_q  <= w_legal ? w_shamt : '0;
            id_q         <= w_sel;
            illegal_q    <= ~w_legal;
            last_grant_q <= w_sel;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= illegal_q ? '0 : alu_out;
          rsp_equal_q  <= ~illegal_q & alu_equal;
          rsp_err_q    <= illegal_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_done_q  <= ops_done_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_op     = alu_op_q;
  assign alu_shamt  = alu_shamt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_equal  = rsp_equal_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_alu_arbiter : vector table, directed corner sequences and random
// traffic against a transaction-level reference model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int C_DW  = 32;
  localparam int C_SW  = 5;
  localparam int C_CW  = 4;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [7:0]        req_op;
  logic [2*C_DW-1:0] req_a, req_b;
  logic [2*C_SW-1:0] req_shamt;
  logic [C_DW-1:0]   alu_in1, alu_in2, alu_out;
  logic [3:0]        alu_op;
  logic [C_SW-1:0]   alu_shamt;
  logic              alu_equal;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_equal, rsp_err;
  logic [C_DW-1:0]   rsp_result;
  logic [C_CW-1:0]   ops_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(C_DW), .SHAMT_W(C_SW), .CNT_W(C_CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_equal(alu_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_equal(rsp_equal), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  // External combinational ALU the arbiter drives.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD: alu_out = alu_in1 + alu_in2;
      OP_SUB: alu_out = alu_in1 - alu_in2;
      OP_AND: alu_out = alu_in1 & alu_in2;
      OP_OR:  alu_out = alu_in1 | alu_in2;
      OP_SLT: alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      OP_SLL: alu_out = alu_in2 << alu_shamt;
      OP_SRL: alu_out = alu_in2 >> alu_shamt;
      default: alu_out = '0;
    endcase
  end
  assign alu_equal = (alu_in1 == alu_in2);

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        err;
    logic [31:0] res;
    logic        eq;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        eq;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Expected outcome of one request, straight from the opcode table.
  function automatic exp_t ref_op(input logic id, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh);
    exp_t e;
    e.id = id; e.op = op; e.a = a; e.b = b; e.sh = sh;
    e.err = 1'b0; e.eq = (a == b); e.res = 32'd0;
    case (op)
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_SLT: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SLL: e.res = b << sh;
      OP_SRL: e.res = b >> sh;
      default: begin e.err = 1'b1; e.eq = 1'b0; e.op = 4'b0000; end
    endcase
    return e;
  endfunction

  function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Transaction model: 0 = free, 1 = operation in the ALU, 2 = response offered.
  int   m_stage = 0;
  logic m_last  = 1'b1;
  int   m_cnt   = 0;
  int   done_total = 0;
  exp_t m_q[$];
  exp_t popped[$];

  always @(negedge clk) begin : mon
    logic [1:0] g;
    exp_t e, p;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_shamt", alu_shamt, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_equal", rsp_equal, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_ops_done", ops_done, 0);
      m_stage = 0; m_last = 1'b1; m_cnt = 0; m_q.delete();
    end else begin
      g = (m_stage == 0) ? ref_grant(req_valid, m_last) : 2'b00;
      chk("req_ready", req_ready, g);
      chk("rsp_valid", rsp_valid, (m_stage == 2) ? 1 : 0);
      chk("ops_done", ops_done, m_cnt % 16);
      if (m_stage == 2 && m_q.size() > 0) begin
        e = m_q[0];
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_equal", rsp_equal, e.eq);
        chk("rsp_err", rsp_err, e.err);
        chk("alu_op", alu_op, e.op);
        chk("alu_in1", alu_in1, e.err ? 32'd0 : e.a);
        chk("alu_in2", alu_in2, e.err ? 32'd0 : e.b);
        if (!e.err) chk("alu_shamt", alu_shamt, e.sh);
      end
      if (m_stage == 0) begin
        if (|(req_valid & g)) begin
          m_q.push_back(ref_op(g[1], req_op[g[1]*4 +: 4], req_a[g[1]*32 +: 32],
                               req_b[g[1]*32 +: 32], req_shamt[g[1]*5 +: 5]));
          m_last  = g[1];
          m_stage = 1;
        end
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (rsp_ready) begin
        p.id = rsp_id; p.res = rsp_result; p.eq = rsp_equal; p.err = rsp_err;
        p.op = alu_op; p.a = alu_in1; p.b = alu_in2; p.sh = alu_shamt;
        popped.push_back(p);
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_cnt++;
        done_total++;
        m_stage = 0;
      end
    end
  end

  task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    req_op[id*4 +: 4]    = op;
    req_a[id*32 +: 32]   = a;
    req_b[id*32 +: 32]   = b;
    req_shamt[id*5 +: 5] = sh;
    req_valid[id]        = 1'b1;
  endtask

  // Returns one cycle after the accepting edge with that valid dropped.
  task automatic wait_accept(input int id, output int cyc);
    cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin
        cyc = c;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    tmo("accept");
  endtask

  task automatic wait_rsp(output exp_t r);
    r = '{default: '0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        r.id = rsp_id; r.res = rsp_result; r.eq = rsp_equal;
        r.err = rsp_err; r.op = alu_op;
        @(posedge clk); #1;
        return;
      end
    end
    tmo("response");
  endtask

  task automatic run_one(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, output exp_t r);
    int cyc;
    set_req(id, op, a, b, sh);
    wait_accept(id, cyc);
    wait_rsp(r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t vt[10];
  logic [3:0] op_tab[8];

  initial begin
    exp_t r;
    int   cyc, got;
    logic [1:0] acc;

    vt[0] = '{OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0};
    vt[1] = '{OP_SUB, 32'd9, 32'd9, 5'd0, 32'd0, 1'b1, 1'b0};
    vt[2] = '{OP_AND, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0, 1'b0};
    vt[3] = '{OP_OR,  32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0};
    vt[4] = '{OP_SLT, 32'd3, 32'd5, 5'd0, 32'd1, 1'b0, 1'b0};
    vt[5] = '{OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b0, 1'b0};
    vt[6] = '{OP_SLL, 32'd0, 32'd1, 5'd4, 32'd16, 1'b0, 1'b0};
    vt[7] = '{OP_SRL, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0, 1'b0};
    vt[8] = '{4'b1111, 32'd3, 32'd3, 5'd2, 32'd0, 1'b0, 1'b1};
    vt[9] = '{OP_SUB, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, 4'b1011};

    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_shamt = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table, requester 0, response always accepted.
    for (int i = 0; i < 10; i++) begin
      run_one(0, vt[i].op, vt[i].a, vt[i].b, vt[i].sh, r);
      chk("vec_result", r.res, vt[i].res);
      chk("vec_equal", r.eq, vt[i].eq);
      chk("vec_err", r.err, vt[i].err);
      chk("vec_id", r.id, 0);
      chk("vec_ops_done", ops_done, i + 1);
    end

    // Both requesters valid every cycle: grants must alternate 0,1,0,1.
    do_reset();
    popped.delete();
    set_req(0, OP_SUB, 32'd9, 32'd9, 5'd0);
    set_req(1, OP_SLL, 32'd0, 32'd1, 5'd4);
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        @(negedge clk);
        if (|(req_valid & req_ready)) begin
          got = 1;
          chk("tie_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      if (got == 0) tmo("tie_grant");
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    wait_rsp(r);
    chk("tie_rsp_count", popped.size(), 4);
    if (popped.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("tie_rsp_id", popped[k].id, k % 2);
        chk("tie_rsp_result", popped[k].res, (k % 2 == 0) ? 32'd0 : 32'd16);
        chk("tie_rsp_equal", popped[k].eq, (k % 2 == 0) ? 1 : 0);
      end
    end

    // Response backpressure for 5 cycles with requester 1 pending.
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 32'd1, 32'd2, 5'd0);
    set_req(1, OP_OR, 32'd3, 32'd4, 5'd0);
    wait_accept(0, cyc);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    if (got == 0) tmo("bp_rsp_valid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_result", rsp_result, 32'd3);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(1, cyc);
    chk("bp_release_delay", cyc, 1);
    wait_rsp(r);
    chk("bp_req1_result", r.res, 32'd7);
    chk("bp_req1_id", r.id, 1);

    // Illegal opcode from requester 1, then a legal one.
    run_one(1, 4'b1111, 32'd3, 32'd4, 5'd1, r);
    chk("ill_err", r.err, 1);
    chk("ill_result", r.res, 0);
    chk("ill_equal", r.eq, 0);
    chk("ill_alu_op", r.op, 0);
    run_one(1, OP_OR, 32'd3, 32'd4, 5'd0, r);
    chk("post_ill_result", r.res, 32'd7);
    chk("post_ill_err", r.err, 0);

    // Reset asserted while the operation is in ISSUE.
    set_req(0, OP_ADD, 32'd5, 32'd7, 5'd0);
    wait_accept(0, cyc);
    rst_n = 1'b0;
    #1;
    chk("ares_rsp_valid", rsp_valid, 0);
    chk("ares_alu_in1", alu_in1, 0);
    chk("ares_alu_in2", alu_in2, 0);
    chk("ares_ops_done", ops_done, 0);
    chk("ares_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ares_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    set_req(0, OP_ADD, 32'd1, 32'd1, 5'd0);
    set_req(1, OP_ADD, 32'd2, 32'd2, 5'd0);
    @(negedge clk);
    chk("ares_first_tie", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(r);
    chk("ares_first_id", r.id, 0);
    chk("ares_first_result", r.res, 32'd2);

    // Random traffic against the reference model.
    do_reset();
    got = done_total + 150;
    acc = 2'b00;
    for (int c = 0; c < 4000 && done_total < got; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          logic [31:0] a;
          a = $urandom;
          set_req(i, op_tab[$urandom_range(0, 7)], a,
                  ($urandom_range(0, 3) == 0) ? a : $urandom, 5'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    if (done_total < got) tmo("random_traffic");
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Completion counter wrap.
    do_reset();
    for (int i = 0; i < 15; i++) run_one(0, OP_ADD, i, 32'd1, 5'd0, r);
    chk("cnt_before_wrap", ops_done, 15);
    run_one(1, OP_ADD, 32'd1, 32'd1, 5'd0, r);
    chk("cnt_wrap", ops_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
